// File: rtl/gat_load_pkg.sv
// Shared types and constants for the GAT load sequencer.
package gat_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_H,
        LD_NI,
        LD_W,
        WAIT_LO,
        WAIT_HI,
        FIN
    } state_t;

    // BRAM ports are byte addressed; every word is 4 bytes apart.
    localparam int ADDR_LSB = 2;

endpackage

// File: rtl/gat_load_wr_port.sv
// Registered BRAM write driver: one write per accepted beat, byte address,
// word index counter and last-beat compare against the section count.
module gat_load_wr_port
    import gat_load_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   wr_i,
    input  logic [DW-1:0]          data_i,
    input  logic [AW:0]            cnt_i,
    output logic                   last_o,
    output logic [DW-1:0]          din_o,
    output logic                   ena_o,
    output logic                   wea_o,
    output logic [AW+ADDR_LSB-1:0] addra_o
);

    logic [AW-1:0]          idx_q;
    logic                   ena_q;
    logic [DW-1:0]          din_q;
    logic [AW+ADDR_LSB-1:0] addr_q;

    assign last_o  = ({1'b0, idx_q} == (cnt_i - (AW+1)'(1)));
    assign din_o   = din_q;
    assign ena_o   = ena_q;
    assign wea_o   = ena_q;
    assign addra_o = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            ena_q  <= 1'b0;
            din_q  <= '0;
            addr_q <= '0;
        end else begin
            ena_q <= wr_i;
            if (clear_i) begin
                idx_q <= '0;
            end else if (wr_i) begin
                idx_q <= idx_q + AW'(1);
            end
            // din/addra hold their last values between writes
            if (wr_i) begin
                din_q  <= data_i;
                addr_q <= {idx_q, {ADDR_LSB{1'b0}}};
            end
        end
    end

endmodule

// File: rtl/gat_load_sched.sv
// GAT host-side load sequencer: streams H-data, node-info and weights into
// their BRAMs, then supervises the accelerator run with a watchdog.
//
//   state   | meaning
//   IDLE    | waiting for start
//   LD_H    | loading H-data BRAM
//   LD_NI   | loading node-info BRAM
//   LD_W    | loading weight BRAM
//   WAIT_LO | waiting for gat_ready to drop (run started)
//   WAIT_HI | waiting for gat_ready to rise (run finished)
//   FIN     | one-cycle done pulse
module gat_load_sched
    import gat_load_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int H_DATA_WIDTH     = 19,
    parameter int NODE_INFO_WIDTH  = 20,
    parameter int H_DATA_ADDR_W    = 18,
    parameter int NODE_INFO_ADDR_W = 14,
    parameter int WEIGHT_ADDR_W    = 15,
    parameter int TMO_W            = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             cfg_layer,
    input  logic [H_DATA_ADDR_W:0]           cfg_h_cnt,
    input  logic [NODE_INFO_ADDR_W:0]        cfg_ni_cnt,
    input  logic [WEIGHT_ADDR_W:0]           cfg_w_cnt,
    input  logic [TMO_W-1:0]                 cfg_tmo,
    input  logic [31:0]                      s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [H_DATA_WIDTH-1:0]          h_data_bram_din,
    output logic                             h_data_bram_ena,
    output logic                             h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]         h_data_bram_addra,
    output logic [NODE_INFO_WIDTH-1:0]       h_node_info_bram_din,
    output logic                             h_node_info_bram_ena,
    output logic                             h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]      h_node_info_bram_addra,
    output logic [DATA_WIDTH-1:0]            wgt_bram_din,
    output logic                             wgt_bram_ena,
    output logic                             wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]         wgt_bram_addra,
    output logic                             h_data_bram_load_done,
    output logic                             h_node_info_bram_load_done,
    output logic                             wgt_bram_load_done,
    output logic                             gat_layer,
    input  logic                             gat_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             err_tmo
);

    state_t                    state_q;
    logic [H_DATA_ADDR_W:0]    h_cnt_q;
    logic [NODE_INFO_ADDR_W:0] ni_cnt_q;
    logic [WEIGHT_ADDR_W:0]    w_cnt_q;
    logic [TMO_W-1:0]          tmo_q;
    logic [TMO_W-1:0]          wd_q;
    logic                      layer_q;
    logic                      h_done_q;
    logic                      ni_done_q;
    logic                      w_done_q;
    logic                      done_q;
    logic                      err_q;

    logic acc, acc_h, acc_ni, acc_w;
    logic last_h, last_ni, last_w;
    logic clear;
    logic unused_hi;

    assign unused_hi = ^s_data[31:NODE_INFO_WIDTH];

    // Zero-count sections never raise ready, so they consume no beats.
    assign s_ready = ((state_q == LD_H)  && (h_cnt_q  != '0)) ||
                     ((state_q == LD_NI) && (ni_cnt_q != '0)) ||
                     ((state_q == LD_W)  && (w_cnt_q  != '0));

    assign acc    = s_valid && s_ready && !abort;
    assign acc_h  = acc && (state_q == LD_H);
    assign acc_ni = acc && (state_q == LD_NI);
    assign acc_w  = acc && (state_q == LD_W);
    assign clear  = (state_q == IDLE);

    assign busy                       = (state_q != IDLE);
    assign done                       = done_q;
    assign err_tmo                    = err_q;
    assign gat_layer                  = layer_q;
    assign h_data_bram_load_done      = h_done_q;
    assign h_node_info_bram_load_done = ni_done_q;
    assign wgt_bram_load_done         = w_done_q;

    gat_load_wr_port #(.DW(H_DATA_WIDTH), .AW(H_DATA_ADDR_W)) u_wr_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .wr_i    (acc_h),
        .data_i  (s_data[H_DATA_WIDTH-1:0]),
        .cnt_i   (h_cnt_q),
        .last_o  (last_h),
        .din_o   (h_data_bram_din),
        .ena_o   (h_data_bram_ena),
        .wea_o   (h_data_bram_wea),
        .addra_o (h_data_bram_addra)
    );

    gat_load_wr_port #(.DW(NODE_INFO_WIDTH), .AW(NODE_INFO_ADDR_W)) u_wr_ni (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .wr_i    (acc_ni),
        .data_i  (s_data[NODE_INFO_WIDTH-1:0]),
        .cnt_i   (ni_cnt_q),
        .last_o  (last_ni),
        .din_o   (h_node_info_bram_din),
        .ena_o   (h_node_info_bram_ena),
        .wea_o   (h_node_info_bram_wea),
        .addra_o (h_node_info_bram_addra)
    );

    gat_load_wr_port #(.DW(DATA_WIDTH), .AW(WEIGHT_ADDR_W)) u_wr_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .wr_i    (acc_w),
        .data_i  (s_data[DATA_WIDTH-1:0]),
        .cnt_i   (w_cnt_q),
        .last_o  (last_w),
        .din_o   (wgt_bram_din),
        .ena_o   (wgt_bram_ena),
        .wea_o   (wgt_bram_wea),
        .addra_o (wgt_bram_addra)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            h_cnt_q   <= '0;
            ni_cnt_q  <= '0;
            w_cnt_q   <= '0;
            tmo_q     <= '0;
            wd_q      <= '0;
            layer_q   <= 1'b0;
            h_done_q  <= 1'b0;
            ni_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                h_done_q  <= 1'b0;
                ni_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= LD_H;
                            h_cnt_q   <= cfg_h_cnt;
                            ni_cnt_q  <= cfg_ni_cnt;
                            w_cnt_q   <= cfg_w_cnt;
                            tmo_q     <= cfg_tmo;
                            layer_q   <= cfg_layer;
                            err_q     <= 1'b0;
                            h_done_q  <= 1'b0;
                            ni_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end
                    end
                    LD_H: begin
                        if ((h_cnt_q == '0) || (acc_h && last_h)) begin
                            state_q  <= LD_NI;
                            h_done_q <= 1'b1;
                        end
                    end
                    LD_NI: begin
                        if ((ni_cnt_q == '0) || (acc_ni && last_ni)) begin
                            state_q   <= LD_W;
                            ni_done_q <= 1'b1;
                        end
                    end
                    LD_W: begin
                        if ((w_cnt_q == '0) || (acc_w && last_w)) begin
                            state_q  <= WAIT_LO;
                            w_done_q <= 1'b1;
                            wd_q     <= '0;
                        end
                    end
                    WAIT_LO, WAIT_HI: begin
                        wd_q <= wd_q + TMO_W'(1);
                        // Watchdog wins over a same-cycle gat_ready transition.
                        if ((tmo_q != '0) && (wd_q == tmo_q - TMO_W'(1))) begin
                            state_q   <= IDLE;
                            err_q     <= 1'b1;
                            h_done_q  <= 1'b0;
                            ni_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else if ((state_q == WAIT_LO) && !gat_ready) begin
                            state_q <= WAIT_HI;
                        end else if ((state_q == WAIT_HI) && gat_ready) begin
                            state_q   <= FIN;
                            done_q    <= 1'b1;
                            h_done_q  <= 1'b0;
                            ni_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end
                    end
                    FIN:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/gat_load_sched.md
Name: gat_load_sched

Overview:
- Host-side sequencer for the GAT accelerator top. Takes a single 32-bit beat stream and loads the H-data, H-node-info and weight BRAMs in that fixed order, driving byte-addressed BRAM write ports.
- Raises each section's load_done level and sets the layer select.
- Then supervises the accelerator run via gat_ready, with a watchdog.
- Sits between the AXI-stream/DMA side and the accelerator's register-bank and BRAM inputs.

Parameters:
- DATA_WIDTH, 8, weight word width.
- H_DATA_WIDTH, 19, H sparse word width (value + column index).
- NODE_INFO_WIDTH, 20, node-info word width.
- H_DATA_ADDR_W, 18, H-data word-index width.
- NODE_INFO_ADDR_W, 14, node-info word-index width.
- WEIGHT_ADDR_W, 15, weight word-index width.
- TMO_W, 32, watchdog counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- cfg_layer  in  1  layer select, latched at start.
- cfg_h_cnt  in  H_DATA_ADDR_W+1  H-data beats to load.
- cfg_ni_cnt  in  NODE_INFO_ADDR_W+1  node-info beats to load.
- cfg_w_cnt  in  WEIGHT_ADDR_W+1  weight beats to load.
- cfg_tmo  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
- latched at start: cfg_h_cnt, cfg_ni_cnt, cfg_w_cnt, cfg_tmo.
- s_data  in  32  stream payload; the low bits are used.
- s_valid  in  1  stream valid.
- s_ready  out  1  stream ready.
- h_data_bram_din/ena/wea/addra  out  H_DATA_WIDTH/1/1/H_DATA_ADDR_W+2  H-data write port; byte address.
- h_node_info_bram_din/ena/wea/addra  out  NODE_INFO_WIDTH/1/1/NODE_INFO_ADDR_W+2  node-info write port.
- wgt_bram_din/ena/wea/addra  out  DATA_WIDTH/1/1/WEIGHT_ADDR_W+2  weight write port.
- h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1 each  section-complete levels.
- gat_layer  out  1  latched cfg_layer.
- gat_ready  in  1  accelerator idle/finished.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err_tmo  out  1  sticky watchdog error; cleared by start.

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0.
- States and transitions:
  - IDLE: start goes to LD_H.
  - LD_H to LD_NI, LD_NI to LD_W, LD_W to WAIT_LO.
  - WAIT_LO goes to WAIT_HI when gat_ready==0 is seen.
  - WAIT_HI goes to FIN when gat_ready==1 is seen.
  - FIN goes to IDLE after one cycle.
- s_ready is 1 only in LD_H, LD_NI and LD_W. A beat is accepted when s_valid && s_ready.
- Write of an accepted beat:
  - Registered, 1-cycle latency: the cycle after acceptance, the section's ena=wea=1, din=s_data[width-1:0], addra={idx,2'b00}.
  - idx starts at 0 and increments per accepted beat; it resets to 0 at each section entry.
  - In every other cycle ena=wea=0; din and addra hold their last values.
- Section end:
  - A section ends on the cycle its last beat (idx==cnt-1) is accepted.
  - Its load_done rises one cycle later, aligned with the final write, and stays high until the next accepted start or abort.
  - The next section's s_ready is valid in the cycle after the last acceptance, so beats flow with no bubble requirement.
- Zero count: the state is skipped in one cycle with no writes and no beats consumed; its load_done still rises.
- Watchdog:
  - A counter clears on entry to WAIT_LO and increments in WAIT_LO and WAIT_HI.
  - When cfg_tmo!=0 and counter==cfg_tmo-1: set err_tmo, drop all load_done flags and go to IDLE. No done pulse is issued.
- FIN: done=1 for one cycle; the load_done flags drop in the same cycle.
- Abort:
  - Same-cycle decision; the next state is IDLE.
  - Flags clear, and any write registered in that cycle is suppressed (ena=0 next cycle).
  - err_tmo is not set by abort.
- Start:
  - Start in a non-IDLE state is ignored.
  - Start together with abort: abort wins.
  - Start in IDLE clears err_tmo.
- gat_layer updates only on an accepted start.

Decomposition:
- Package gat_load_pkg: state enum (IDLE, LD_H, LD_NI, LD_W, WAIT_LO, WAIT_HI, FIN) and a byte-address shift constant ADDR_LSB=2.
- One natural sub-module, gat_load_wr_port: a parameterised registered BRAM write driver (index counter, din/addr/ena/wea regs, last-beat compare). It is instantiated three times. The FSM and watchdog stay in the top.

Test Plan:
- Counts (3,2,4), continuous s_valid, data 0x10.. -> H addra 0,4,8; NI addra 0,4; W addra 0,4,8,12. Nine writes total, each 1 cycle after acceptance. Each done flag rises with its last write.
- Same counts with s_valid toggling every other cycle -> identical write contents and addresses; no beat is dropped or duplicated.
- cfg_ni_cnt=0 -> no NI writes; h_node_info_bram_load_done rises one cycle after LD_H ends; weight loading proceeds.
- After load, gat_ready 1->0 (5 cycles) ->1, cfg_tmo=100 -> a single done pulse, flags cleared, busy=0.
- cfg_tmo=20 with gat_ready held 1 -> err_tmo=1 after 20 cycles in WAIT_LO, state IDLE, no done; the next start clears err_tmo.
- Abort on the 2nd H beat, then reset asserted mid-LD_W on a rerun -> IDLE, no further writes, all outputs 0 immediately on rst_n low.
